// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: fetch/data sharing of one single-port memory.
// Optional ARB_ROUND_ROBIN_EN: alternate winners on simultaneous requests.
module core_mem_arbiter #(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        I_REQ,
  input  logic [31:0] I_ADDR,
  output logic        I_GNT,
  output logic        I_RVALID,
  output logic [31:0] I_RDATA,
  input  logic        D_REQ,
  input  logic        D_WE,
  input  logic [31:0] D_ADDR,
  input  logic [31:0] D_WDATA,
  input  logic [3:0]  D_BE,
  output logic        D_GNT,
  output logic        D_RVALID,
  output logic [31:0] D_RDATA,
  output logic        M_REQ,
  output logic        M_WE,
  output logic [31:0] M_ADDR,
  output logic [31:0] M_WDATA,
  output logic [3:0]  M_BE,
  input  logic [31:0] M_RDATA
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_t;

  localparam logic [2:0] LAT = 3'(RD_LATENCY);

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  cnt;
  logic [2:0]  cnt_nxt;
  port_t       owner;
  port_t       owner_nxt;

  logic        sel_d;
  logic        gnt_i;
  logic        gnt_d;
  logic        done;

  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;

  logic        i_rvalid_q;
  logic        d_rvalid_q;
  logic [31:0] i_rdata_q;
  logic [31:0] d_rdata_q;

`ifdef ARB_ROUND_ROBIN_EN
  port_t last_gnt;

  // Remember who won last so a conflict goes to the other port.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      last_gnt <= PORT_I;
    end else if (gnt_d) begin
      last_gnt <= PORT_D;
    end else if (gnt_i) begin
      last_gnt <= PORT_I;
    end
  end

  // D wins alone, or on a conflict when I won last time.
  always_comb begin
    sel_d = D_REQ & (~I_REQ | (last_gnt == PORT_I));
  end
`else
  // Fixed priority: data side always beats fetch.
  always_comb begin
    sel_d = D_REQ;
  end
`endif

  // State, latency counter and read owner.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= ST_IDLE;
      cnt   <= 3'd0;
      owner <= PORT_I;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      owner <= owner_nxt;
    end
  end

  // Grant in IDLE; count the read latency in WAIT.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    owner_nxt = owner;
    gnt_i     = 1'b0;
    gnt_d     = 1'b0;
    done      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        gnt_d = sel_d;
        gnt_i = I_REQ & ~sel_d;
        if (gnt_d & ~D_WE) begin
          owner_nxt = PORT_D;
          cnt_nxt   = 3'd1;
          state_nxt = ST_WAIT;
        end else if (gnt_i) begin
          owner_nxt = PORT_I;
          cnt_nxt   = 3'd1;
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt == LAT) begin
          done      = 1'b1;
          cnt_nxt   = 3'd0;
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt + 3'd1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Steer the granted request onto the memory bus.
  always_comb begin
    m_req   = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_be    = '0;
    unique case (1'b1)
      gnt_d: begin
        m_req   = 1'b1;
        m_we    = D_WE;
        m_addr  = D_ADDR;
        m_wdata = D_WDATA;
        m_be    = D_BE;
      end
      gnt_i: begin
        m_req  = 1'b1;
        m_addr = I_ADDR;
        m_be   = 4'hF;
      end
      default: begin
      end
    endcase
  end

  // One-cycle valid pulse to the read owner after capture.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
    end else begin
      i_rvalid_q <= done & (owner == PORT_I);
      d_rvalid_q <= done & (owner == PORT_D);
    end
  end

  // Capture read data into the owner's holding register.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else if (done) begin
      if (owner == PORT_D) begin
        d_rdata_q <= M_RDATA;
      end else begin
        i_rdata_q <= M_RDATA;
      end
    end
  end

  // Everything reads as zero while reset is held.
  always_comb begin
    I_GNT    = RST_N & gnt_i;
    D_GNT    = RST_N & gnt_d;
    I_RVALID = RST_N & i_rvalid_q;
    D_RVALID = RST_N & d_rvalid_q;
    I_RDATA  = RST_N ? i_rdata_q : '0;
    D_RDATA  = RST_N ? d_rdata_q : '0;
    M_REQ    = RST_N & m_req;
    M_WE     = RST_N & m_we;
    M_ADDR   = RST_N ? m_addr : '0;
    M_WDATA  = RST_N ? m_wdata : '0;
    M_BE     = RST_N ? m_be : '0;
  end

endmodule
